// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiply sequencer: op encoding,
// FSM states and datapath sizing.
package mul_pkg;
  localparam int MUL_W   = 0;
  localparam int MULH_W  = 1;
  localparam int MULH_WU = 2;

  localparam int CHUNK_W = 8;
  localparam int N_ITER  = 4;
  localparam int PROD_W  = 66;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/mul_chunk.sv
// Signed 33-bit by unsigned 8-bit partial product, one src2 slice per call.
module mul_chunk
  import mul_pkg::*;
(
  input  logic [32:0]        a,
  input  logic [CHUNK_W-1:0] b,
  output logic [40:0]        p
);
  logic [40:0] a_ext_s;
  logic [40:0] b_ext_s;

  // Product truncated to 41 bits is exact once a is sign- and b zero-extended.
  always_comb begin
    a_ext_s = {{8{a[32]}}, a};
    b_ext_s = {33'd0, b};
    p       = a_ext_s * b_ext_s;
  end
endmodule

// File: rtl/mul_iter_ctrl.sv
// Iterative multiply sequencer: accepts one op, accumulates four 8-bit slices
// of src2 into a 66-bit product, then holds the selected half for MEM.
module mul_iter_ctrl
  import mul_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_src1,
  input  logic [31:0]      req_src2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_result,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy
);
  state_t            state_r, state_s;
  logic [1:0]        cnt_r;
  logic [PROD_W-1:0] acc_r, acc_s;
  logic [32:0]       s1_r, s2_r;
  logic [2:0]        op_r;
  logic              accept_s;
  logic [7:0]        chunk_s;
  logic [40:0]       pp_s;
  logic [PROD_W-1:0] pp_ext_s, corr_s;
  logic [31:0]       sel_s;

  mul_chunk u_chunk (
    .a (s1_r),
    .b (chunk_s),
    .p (pp_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    state_s = state_r;
    if (flush) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_s = req_valid ? CALC : IDLE;
        CALC:    state_s = (cnt_r == 2'd3) ? DONE : CALC;
        DONE:    state_s = resp_ready ? IDLE : DONE;
        default: state_s = IDLE;
      endcase
    end
  end

  // Handshake and status outputs.
  always_comb begin
    req_ready  = (state_r == IDLE) && !flush;
    busy       = (state_r != IDLE);
    resp_valid = (state_r == DONE);
  end

  // Slice select, shift-accumulate, sign-bit correction and half select.
  always_comb begin
    accept_s = (state_r == IDLE) && req_valid && !flush;
    case (cnt_r)
      2'd0:    chunk_s = s2_r[7:0];
      2'd1:    chunk_s = s2_r[15:8];
      2'd2:    chunk_s = s2_r[23:16];
      2'd3:    chunk_s = s2_r[31:24];
      default: chunk_s = 8'd0;
    endcase
    pp_ext_s = {{25{pp_s[40]}}, pp_s} << {cnt_r, 3'b000};
    // The top bit of s2 carries weight -2^32, applied once on the last slice.
    if ((cnt_r == 2'd3) && s2_r[32]) begin
      corr_s = {s1_r[32], s1_r, 32'd0};
    end else begin
      corr_s = {PROD_W{1'b0}};
    end
    acc_s = acc_r + pp_ext_s - corr_s;
    sel_s = (op_r[MUL_W] ? acc_s[31:0] : 32'd0)
          | ((op_r[MULH_W] | op_r[MULH_WU]) ? acc_s[63:32] : 32'd0);
  end

  // Operand capture, accumulator/counter update and result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r       <= 2'd0;
      acc_r       <= {PROD_W{1'b0}};
      s1_r        <= 33'd0;
      s2_r        <= 33'd0;
      op_r        <= 3'd0;
      resp_result <= 32'd0;
      resp_tag    <= {TAG_W{1'b0}};
    end else if (accept_s) begin
      cnt_r    <= 2'd0;
      acc_r    <= {PROD_W{1'b0}};
      s1_r     <= {req_op[MULH_W] & req_src1[31], req_src1};
      s2_r     <= {req_op[MULH_W] & req_src2[31], req_src2};
      op_r     <= req_op;
      resp_tag <= req_tag;
    end else if ((state_r == CALC) && !flush) begin
      acc_r <= acc_s;
      cnt_r <= cnt_r + 2'd1;
      if (cnt_r == 2'd3) begin
        resp_result <= sel_s;
      end
    end
  end
endmodule

// File: tb/tb_mul_iter_ctrl.sv
// Directed-vector bench for mul_iter_ctrl with hand-computed products.
module tb_mul_iter_ctrl;
  logic        clk = 1'b0;
  logic        reset, flush, req_valid, req_ready, resp_valid, resp_ready, busy;
  logic [2:0]  req_op;
  logic [31:0] req_src1, req_src2, resp_result;
  logic [4:0]  req_tag, resp_tag;
  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12] = '{
    '{3'b001, 32'h00000003, 32'hFFFFFFFB, 5'h0A, 32'hFFFFFFF1},
    '{3'b010, 32'h80000000, 32'h80000000, 5'h11, 32'h40000000},
    '{3'b010, 32'hFFFFFFFF, 32'h00000001, 5'h12, 32'hFFFFFFFF},
    '{3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h13, 32'hFFFFFFFE},
    '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h14, 32'h00000001},
    '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h01, 32'h00000000},
    '{3'b000, 32'h00001234, 32'h00005678, 5'h15, 32'h00000000},
    '{3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h16, 32'hFFFFFFFF},
    '{3'b100, 32'h00010000, 32'h00010000, 5'h1F, 32'h00000001},
    '{3'b010, 32'hFFFFFFFE, 32'h00000003, 5'h00, 32'hFFFFFFFF},
    '{3'b001, 32'h01010101, 32'h01010101, 5'h02, 32'h04030201},
    '{3'b100, 32'h01010101, 32'h01010101, 5'h03, 32'h00010203}
  };

  mul_iter_ctrl #(.TAG_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_tag(resp_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single cycle; returns in cycle T+1.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag);
    req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b; req_tag = tag;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_op = 3'd0; req_src1 = 32'd0; req_src2 = 32'd0; req_tag = 5'd0;
    tick(); tick();
    reset = 1'b0;
    #1;
    vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    vectors++; if (resp_result !== 32'd0) begin miscompares++; $display("FAIL reset_result: got %h want 0", resp_result); end
    vectors++; if (resp_tag !== 5'd0) begin miscompares++; $display("FAIL reset_tag: got %h want 0", resp_tag); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_arith();
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL arith%0d_busy: got %b want 1", i, busy); end
      repeat (3) tick();
      vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL arith%0d_early_valid: got %b want 0 at T+4", i, resp_valid); end
      tick();
      vectors++; if (resp_valid !== 1'b1) begin miscompares++; $display("FAIL arith%0d_valid: got %b want 1 at T+5", i, resp_valid); end
      vectors++; if (resp_result !== vecs[i].exp) begin miscompares++; $display("FAIL arith%0d_result: got %h want %h", i, resp_result, vecs[i].exp); end
      vectors++; if (resp_tag !== vecs[i].tag) begin miscompares++; $display("FAIL arith%0d_tag: got %h want %h", i, resp_tag, vecs[i].tag); end
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      vectors++; if ((busy !== 1'b0) || (resp_valid !== 1'b0)) begin miscompares++; $display("FAIL arith%0d_release: got busy=%b valid=%b want 0/0", i, busy, resp_valid); end
    end
  endtask

  task automatic test_backpressure();
    issue(3'b010, 32'h80000000, 32'h80000000, 5'h07);
    repeat (4) tick();
    // A competing request is held up while DONE waits for MEM.
    req_valid = 1'b1; req_op = 3'b001; req_src1 = 32'd3; req_src2 = 32'd5; req_tag = 5'h09;
    #1;
    for (int i = 0; i < 11; i++) begin
      vectors++; if ((resp_valid !== 1'b1) || (resp_result !== 32'h40000000) || (resp_tag !== 5'h07))
        begin miscompares++; $display("FAIL bp_hold%0d: got v=%b r=%h t=%h want 1/40000000/07", i, resp_valid, resp_result, resp_tag); end
      vectors++; if ((req_ready !== 1'b0) || (busy !== 1'b1))
        begin miscompares++; $display("FAIL bp_status%0d: got ready=%b busy=%b want 0/1", i, req_ready, busy); end
      if (i < 10) tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    vectors++; if ((req_ready !== 1'b1) || (busy !== 1'b0) || (resp_valid !== 1'b0))
      begin miscompares++; $display("FAIL bp_idle: got ready=%b busy=%b valid=%b want 1/0/0", req_ready, busy, resp_valid); end
    tick();
    req_valid = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL bp_b2b_accept: got busy=%b want 1", busy); end
    repeat (4) tick();
    vectors++; if ((resp_valid !== 1'b1) || (resp_result !== 32'h0000000F) || (resp_tag !== 5'h09))
      begin miscompares++; $display("FAIL bp_b2b_result: got v=%b r=%h t=%h want 1/0000000F/09", resp_valid, resp_result, resp_tag); end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_flush_calc();
    issue(3'b001, 32'd2, 32'd3, 5'h03);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    vectors++; if ((busy !== 1'b0) || (resp_valid !== 1'b0))
      begin miscompares++; $display("FAIL flush_calc_idle: got busy=%b valid=%b want 0/0", busy, resp_valid); end
    issue(3'b001, 32'd7, 32'd6, 5'h04);
    for (int k = 0; k < 4; k++) begin
      vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL flush_calc_no_valid%0d: got %b want 0", k, resp_valid); end
      tick();
    end
    vectors++; if ((resp_valid !== 1'b1) || (resp_result !== 32'h0000002A) || (resp_tag !== 5'h04))
      begin miscompares++; $display("FAIL flush_calc_next: got v=%b r=%h t=%h want 1/0000002A/04", resp_valid, resp_result, resp_tag); end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_flush_done();
    issue(3'b001, 32'd9, 32'd9, 5'h05);
    repeat (4) tick();
    flush = 1'b1; resp_ready = 1'b1;
    tick();
    flush = 1'b0; resp_ready = 1'b0;
    vectors++; if ((resp_valid !== 1'b0) || (busy !== 1'b0))
      begin miscompares++; $display("FAIL flush_done: got valid=%b busy=%b want 0/0", resp_valid, busy); end
  endtask

  task automatic test_reset_done();
    issue(3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h1E);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++; if ((resp_valid !== 1'b0) || (busy !== 1'b0) || (req_ready !== 1'b1))
      begin miscompares++; $display("FAIL rst_done_ctrl: got valid=%b busy=%b ready=%b want 0/0/1", resp_valid, busy, req_ready); end
    vectors++; if ((resp_result !== 32'd0) || (resp_tag !== 5'd0))
      begin miscompares++; $display("FAIL rst_done_data: got r=%h t=%h want 0/0", resp_result, resp_tag); end
  endtask

  task automatic test_flush_idle();
    flush = 1'b1;
    req_valid = 1'b1; req_op = 3'b001; req_src1 = 32'd1; req_src2 = 32'd1; req_tag = 5'h08;
    #1;
    vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL flush_idle_ready: got %b want 0", req_ready); end
    tick();
    flush = 1'b0; req_valid = 1'b0;
    vectors++; if ((busy !== 1'b0) || (resp_valid !== 1'b0))
      begin miscompares++; $display("FAIL flush_idle_accept: got busy=%b valid=%b want 0/0", busy, resp_valid); end
    #1;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL flush_idle_recover: got %b want 1", req_ready); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_backpressure();
    test_flush_calc();
    test_flush_done();
    test_reset_done();
    test_flush_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
